// File: rtl/sum_accumulator.sv
// Block accumulator behind adder_4bit: sums N_SAMPLES unsigned samples into a
// saturating register and offers the block total through a valid/ready handshake.
module sum_accumulator #(
  parameter int SUM_W     = 5,
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4,
  localparam int CNT_W    = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf, ovf_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             drain;

  // Adds one sample at ACC_W+1 bits; the carry bit is the saturation flag.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [SUM_W-1:0] x);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {{(ACC_W + 1 - SUM_W){1'b0}}, x};
    if (s[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = s;
    end
  endfunction

  assign accept  = (state == ACCUM) && in_valid;
  assign drain   = (state == HOLD) && out_ready;
  assign sum_ext = sat_add(acc, in_sum);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc_nxt = sum_ext[ACC_W-1:0];
            ovf_nxt = ovf | sum_ext[ACC_W];
            cnt_nxt = cnt + CNT_ONE;
            if (cnt + CNT_ONE == LAST_CNT) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (drain) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = ACCUM;
        end
      endcase
    end
  end

  // Every register returns to zero on reset so a pending block is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == HOLD);
  assign out_total    = acc;
  assign out_overflow = ovf;
  assign out_count    = cnt;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: two accumulator instances (ACC_W=8 and ACC_W=6) driven in
// lockstep and compared every cycle against a block-level arithmetic model.
module tb_sum_accumulator;

  localparam int NS = 4;
  localparam int CW = $clog2(NS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [4:0]    in_sum;
  logic          out_ready;

  logic          rdy8, vld8, ovf8;
  logic [7:0]    tot8;
  logic [CW-1:0] cnt8;
  logic          rdy6, vld6, ovf6;
  logic [5:0]    tot6;
  logic [CW-1:0] cnt6;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int rise_q[$];
  logic prev_vld8 = 1'b0;

  // Model: per instance, the plain integer sum and count of the current block.
  int   m_sum  [2];
  int   m_cnt  [2];
  logic m_hold [2];
  int   m_max  [2] = '{255, 63};

  sum_accumulator #(.SUM_W(5), .ACC_W(8), .N_SAMPLES(NS)) u8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy8), .in_sum(in_sum), .out_valid(vld8), .out_ready(out_ready),
    .out_total(tot8), .out_overflow(ovf8), .out_count(cnt8)
  );

  sum_accumulator #(.SUM_W(5), .ACC_W(6), .N_SAMPLES(NS)) u6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy6), .in_sum(in_sum), .out_valid(vld6), .out_ready(out_ready),
    .out_total(tot6), .out_overflow(ovf6), .out_count(cnt6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sum[i]  = 0;
      m_cnt[i]  = 0;
      m_hold[i] = 1'b0;
    end
  endtask

  function automatic int exp_total(input int i);
    return (m_sum[i] > m_max[i]) ? m_max[i] : m_sum[i];
  endfunction

  task automatic check_outputs();
    chk("rdy8", int'(rdy8), int'(!m_hold[0]));
    chk("vld8", int'(vld8), int'(m_hold[0]));
    chk("cnt8", int'(cnt8), m_cnt[0]);
    chk("tot8", int'(tot8), exp_total(0));
    chk("ovf8", int'(ovf8), int'(m_sum[0] > m_max[0]));
    chk("rdy6", int'(rdy6), int'(!m_hold[1]));
    chk("vld6", int'(vld6), int'(m_hold[1]));
    chk("cnt6", int'(cnt6), m_cnt[1]);
    chk("tot6", int'(tot6), exp_total(1));
    chk("ovf6", int'(ovf6), int'(m_sum[1] > m_max[1]));
    if (vld8 && !prev_vld8) rise_q.push_back(cyc_n);
    prev_vld8 = vld8;
  endtask

  task automatic model_edge(input logic v, input int s, input logic r, input logic c);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end else if (!m_hold[i]) begin
        if (v) begin
          m_sum[i] += s;
          m_cnt[i]++;
          if (m_cnt[i] == NS) m_hold[i] = 1'b1;
        end
      end else if (r) begin
        m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge: drive, check, let one rising edge happen.
  task automatic cyc(input logic v, input int s, input logic r, input logic c);
    in_valid  = v;
    in_sum    = 5'(s);
    out_ready = r;
    clear     = c;
    check_outputs();
    @(posedge clk);
    model_edge(v, s, r, c);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, int'($urandom_range(31)), 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int blk [4];
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Default block with the consumer always ready.
    blk = '{3, 8, 16, 15};
    foreach (blk[k]) cyc(1'b1, blk[k], 1'b1, 1'b0);
    chk("dflt_total", int'(tot8), 42);
    chk("dflt_valid", int'(vld8), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("dflt_ready_after", int'(rdy8), 1);
    chk("dflt_valid_after", int'(vld8), 0);

    // Gapped samples, then five stalled cycles with samples offered.
    blk = '{10, 0, 5, 31};
    foreach (blk[k]) begin
      cyc(1'b1, blk[k], 1'b0, 1'b0);
      idle(2);
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_total", int'(tot8), 46);
      chk("bp_count", int'(cnt8), 4);
      chk("bp_ready", int'(rdy8), 0);
      cyc(1'b1, 9, 1'b0, 1'b0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("bp_drained", int'(vld8), 0);

    // Saturation on the narrow instance, then a clean block.
    for (int k = 0; k < 4; k++) cyc(1'b1, 16, 1'b0, 1'b0);
    chk("sat_total", int'(tot6), 63);
    chk("sat_ovf", int'(ovf6), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1, 1'b0, 1'b0);
    chk("post_sat_total", int'(tot6), 4);
    chk("post_sat_ovf", int'(ovf6), 0);
    cyc(1'b0, 0, 1'b1, 1'b0);

    // Mid-block clear racing a sample.
    cyc(1'b1, 7, 1'b0, 1'b0);
    cyc(1'b1, 9, 1'b0, 1'b0);
    cyc(1'b1, 20, 1'b0, 1'b1);
    chk("clr_count", int'(cnt8), 0);
    chk("clr_total", int'(tot8), 0);
    for (int k = 1; k <= 4; k++) cyc(1'b1, k, 1'b0, 1'b0);
    chk("clr_next_total", int'(tot8), 10);

    // Asynchronous reset while holding a block.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_vld", int'(vld8), 0);
    chk("arst_rdy", int'(rdy8), 1);
    chk("arst_total", int'(tot8), 0);
    chk("arst_count", int'(cnt8), 0);
    chk("arst_ovf", int'(ovf6), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b1, 2, 1'b0, 1'b0);
    chk("arst_next_total", int'(tot8), 8);
    cyc(1'b0, 0, 1'b1, 1'b0);

    // Back-to-back blocks at full throughput.
    rise_q.delete();
    for (int k = 0; k < 11; k++) begin
      if (vld8) begin
        chk("b2b_total", int'(tot8), 124);
        chk("b2b_ovf", int'(ovf8), 0);
      end
      cyc(1'b1, 31, 1'b1, 1'b0);
    end
    check_outputs();
    chk("b2b_pulses", rise_q.size(), 2);
    if (rise_q.size() >= 2) chk("b2b_gap", rise_q[1] - rise_q[0], NS + 1);
    cyc(1'b0, 0, 1'b1, 1'b1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(1'($urandom_range(1)), int'($urandom_range(31)),
          1'($urandom_range(3) != 0), 1'($urandom_range(15) == 0));
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
